// File: rtl/accum_rmw_ctrl.sv
// accum_rmw_ctrl: per-column read-modify-write initiator for the accumulator table.
// Ports: clk/reset (sync, active-high); start + base_addr/num_rows/overwrite pass config;
// psum_valid/psum_data skewed column inputs; tbl_rd_* / tbl_wr_* table ports (1-cycle read latency);
// busy (RUN or DRAIN), done (1-cycle end-of-pass pulse), err (sticky protocol error).
// Build option: define ACCUM_RMW_SAT_EN for a signed saturating adder instead of wrap-around.
module accum_rmw_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_COLS = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [ADDR_W:0]                    num_rows,
  input  logic                               overwrite,
  input  logic [SYS_ARR_COLS-1:0]            psum_valid,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] psum_data,
  output logic [SYS_ARR_COLS-1:0]            tbl_rd_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0]     tbl_rd_addr,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] tbl_rd_data,
  output logic [SYS_ARR_COLS-1:0]            tbl_wr_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0]     tbl_wr_addr,
  output logic [DATA_WIDTH*SYS_ARR_COLS-1:0] tbl_wr_data,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);
  localparam int C = SYS_ARR_COLS;
  localparam int W = DATA_WIDTH;
  localparam int A = ADDR_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [A-1:0] base_q, base_d;
  logic [A:0] rows_q, rows_d;
  logic ovw_q, ovw_d, err_q, err_d, done_q, done_d, viol, all_full;
  logic [C-1:0][A:0] r_q, r_d;
  logic [C-1:0] s1_v_q, s1_v_d, s2_v_q, s2_v_d, wr_v_q, wr_v_d, acc;
  logic [C-1:0][A-1:0] s1_a_q, s1_a_d, s2_a_q, s2_a_d, wr_a_q, wr_a_d;
  logic [C-1:0][W-1:0] s1_p_q, s1_p_d, s2_p_q, s2_p_d, wr_p_q, wr_p_d, sum;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    rows_d = rows_q;
    ovw_d = ovw_q;
    r_d = r_q;
    done_d = 1'b0;
    s1_a_d = s1_a_q;
    s1_p_d = s1_p_q;
    s2_a_d = s2_a_q;
    s2_p_d = s2_p_q;
    wr_a_d = wr_a_q;
    wr_p_d = wr_p_q;
    s1_v_d = '0;
    s2_v_d = s1_v_q;
    wr_v_d = s2_v_q;
    acc = '0;
    sum = '0;
    all_full = 1'b1;
    for (int c = 0; c < C; c++) begin
      acc[c] = state_q == RUN && psum_valid[c] && r_q[c] < rows_q;
      s1_v_d[c] = acc[c];
      if (acc[c]) begin
        s1_a_d[c] = base_q + r_q[c][A-1:0];
        s1_p_d[c] = psum_data[c*W +: W];
        r_d[c] = r_q[c] + 1'b1;
      end
      if (s1_v_q[c]) begin
        s2_a_d[c] = s1_a_q[c];
        s2_p_d[c] = s1_p_q[c];
      end
      sum[c] = ovw_q ? s2_p_q[c] : s2_p_q[c] + tbl_rd_data[c*W +: W];
`ifdef ACCUM_RMW_SAT_EN
      if (!ovw_q && s2_p_q[c][W-1] == tbl_rd_data[c*W+W-1] && sum[c][W-1] != s2_p_q[c][W-1])
        sum[c] = {s2_p_q[c][W-1], {(W-1){~s2_p_q[c][W-1]}}};
`endif
      if (s2_v_q[c]) begin
        wr_a_d[c] = s2_a_q[c];
        wr_p_d[c] = sum[c];
      end
      all_full = all_full && r_d[c] == rows_q;
    end
    viol = |(psum_valid & ~acc);
    err_d = ((state_q == IDLE && start) ? 1'b0 : err_q) | viol;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      base_d = base_addr;
      rows_d = num_rows;
      ovw_d = overwrite;
      r_d = '0;
    end
    if (state_q == RUN && all_full) state_d = DRAIN;
    if (state_q == DRAIN && s1_v_d == '0 && s2_v_d == '0 && wr_v_d == '0) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      rows_q <= '0;
      ovw_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      r_q <= '0;
      s1_v_q <= '0;
      s2_v_q <= '0;
      wr_v_q <= '0;
      s1_a_q <= '0;
      s2_a_q <= '0;
      wr_a_q <= '0;
      s1_p_q <= '0;
      s2_p_q <= '0;
      wr_p_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      rows_q <= rows_d;
      ovw_q <= ovw_d;
      err_q <= err_d;
      done_q <= done_d;
      r_q <= r_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      wr_v_q <= wr_v_d;
      s1_a_q <= s1_a_d;
      s2_a_q <= s2_a_d;
      wr_a_q <= wr_a_d;
      s1_p_q <= s1_p_d;
      s2_p_q <= s2_p_d;
      wr_p_q <= wr_p_d;
    end
  end
  assign tbl_rd_en = s1_v_q & {C{~ovw_q}};
  assign tbl_rd_addr = s1_a_q;
  assign tbl_wr_en = wr_v_q;
  assign tbl_wr_addr = wr_a_q;
  assign tbl_wr_data = wr_p_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_accum_rmw_ctrl.sv
// tb_accum_rmw_ctrl: randomized self-checking bench for accum_rmw_ctrl against a table-level model.
module tb_accum_rmw_ctrl;
  localparam int DW = 8, MR = 4, MC = 16, C = 4, N = MR * (MC / C), AW = $clog2(N);
  localparam int SMAX = 2 ** (DW - 1) - 1, SMIN = -(2 ** (DW - 1));
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_rows = '0;
  logic overwrite = 1'b0;
  logic [C-1:0] psum_valid = '0;
  logic [DW*C-1:0] psum_data = '0;
  logic [C-1:0] tbl_rd_en, tbl_wr_en;
  logic [AW*C-1:0] tbl_rd_addr, tbl_wr_addr;
  logic [DW*C-1:0] tbl_rd_data, tbl_wr_data;
  logic busy, done, err;
  typedef struct {int t; logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  exp_t rq[C][$];
  exp_t wq[C][$];
  logic [DW-1:0] mem[C][N];
  logic [DW-1:0] mdl[C][N];
  logic [DW-1:0] snap[C][N];
  bit wrt[C][N];
  bit wsnap[C][N];
  int cyc = 0, errors = 0, checks = 0, nr = 0, bs = 0, last_wr = 0;
  int rc[C];
  bit ow = 0, run = 0, exp_err = 0;
  always #5 clk = ~clk;
  accum_rmw_ctrl #(.DATA_WIDTH(DW), .MAX_OUT_ROWS(MR), .MAX_OUT_COLS(MC), .SYS_ARR_COLS(C)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .overwrite(overwrite), .psum_valid(psum_valid), .psum_data(psum_data),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .busy(busy), .done(done), .err(err));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < C; c++) begin
      if (tbl_rd_en[c]) tbl_rd_data[c*DW +: DW] <= mem[c][tbl_rd_addr[c*AW +: AW]];
      if (tbl_wr_en[c]) mem[c][tbl_wr_addr[c*AW +: AW]] <= tbl_wr_data[c*DW +: DW];
    end
  end
  always @(negedge clk) begin
    for (int c = 0; c < C; c++) begin
      bit rx, wx;
      rx = rq[c].size() > 0 && rq[c][0].t == cyc;
      wx = wq[c].size() > 0 && wq[c][0].t == cyc;
      if (tbl_rd_en[c] || rx) begin
        checks++;
        if (!(tbl_rd_en[c] && rx && tbl_rd_addr[c*AW +: AW] == rq[c][0].a)) begin
          errors++;
          $display("FAIL rd col%0d cycle %0d: got en=%0b addr=%0d, required en=%0b addr=%0d",
                   c, cyc, tbl_rd_en[c], tbl_rd_addr[c*AW +: AW], rx, rx ? rq[c][0].a : 0);
        end
        if (rx) void'(rq[c].pop_front());
      end
      if (tbl_wr_en[c] || wx) begin
        checks++;
        if (!(tbl_wr_en[c] && wx && tbl_wr_addr[c*AW +: AW] == wq[c][0].a && tbl_wr_data[c*DW +: DW] == wq[c][0].d)) begin
          errors++;
          $display("FAIL wr col%0d cycle %0d: got en=%0b addr=%0d data=%0d, required en=%0b addr=%0d data=%0d",
                   c, cyc, tbl_wr_en[c], tbl_wr_addr[c*AW +: AW], tbl_wr_data[c*DW +: DW],
                   wx, wx ? wq[c][0].a : 0, wx ? wq[c][0].d : 0);
        end
        if (wx) void'(wq[c].pop_front());
      end
    end
  end
  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] st, input logic [DW-1:0] ps);
    int s;
    s = int'($signed(st)) + int'($signed(ps));
`ifdef ACCUM_RMW_SAT_EN
    s = s > SMAX ? SMAX : s < SMIN ? SMIN : s;
`endif
    return s[DW-1:0];
  endfunction
  function automatic bit pass_full();
    for (int c = 0; c < C; c++) if (rc[c] < nr) return 0;
    return 1;
  endfunction
  task automatic drive(input logic [C-1:0] v, input logic [DW*C-1:0] d);
    psum_valid = v;
    psum_data = d;
    for (int c = 0; c < C; c++) begin
      if (v[c] && !(run && rc[c] < nr)) exp_err = 1;
      if (run && v[c] && rc[c] < nr) begin
        int a;
        logic [DW-1:0] p, res;
        a = (bs + rc[c]) % N;
        p = d[c*DW +: DW];
        res = ow ? p : model_add(mdl[c][a], p);
        if (!ow) rq[c].push_back('{cyc + 1, AW'(a), '0});
        wq[c].push_back('{cyc + 3, AW'(a), res});
        mdl[c][a] = res;
        wrt[c][a] = 1;
        rc[c]++;
        last_wr = cyc + 3;
      end
    end
    @(negedge clk);
    psum_valid = '0;
  endtask
  task automatic begin_pass(input int b, input int n, input bit o);
    start = 1;
    base_addr = AW'(b);
    num_rows = (AW+1)'(n);
    overwrite = o;
    @(negedge clk);
    start = 0;
    bs = b;
    nr = n;
    ow = o;
    run = 1;
    exp_err = 0;
    for (int c = 0; c < C; c++) rc[c] = 0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start: got busy=%0b err=%0b, required busy=1 err=0", busy, err);
    end
  endtask
  task automatic finish_pass(input string name);
    bit bad;
    psum_valid = '0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cyc != last_wr + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%0b busy=%0b at cycle %0d, required done=1 busy=0 at cycle %0d",
               name, done, busy, cyc, last_wr + 1);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %0b, required %0b", name, err, exp_err);
    end
    run = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%0b one cycle later, required 0", name, done);
    end
    for (int c = 0; c < C; c++) begin
      bad = rq[c].size() != 0 || wq[c].size() != 0;
      for (int a = 0; a < N; a++) if (wrt[c][a] && mem[c][a] !== mdl[c][a]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s table col%0d: pending rd=%0d wr=%0d or contents differ, required none and equal",
                 name, c, rq[c].size(), wq[c].size());
      end
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset ctrl: got busy/done/err=%b, required 000", {busy, done, err});
    end
    checks++;
    if ({tbl_rd_en, tbl_wr_en} !== '0) begin
      errors++;
      $display("FAIL reset en: got rd=%b wr=%b, required 0", tbl_rd_en, tbl_wr_en);
    end
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_fill();
    begin_pass(0, N, 1);
    for (int t = 0; t < N; t++) drive('1, $urandom);
    finish_pass("fill");
  endtask
  task automatic test_overwrite();
    logic [DW*C-1:0] d;
    begin_pass(5, 2, 1);
    d = $urandom;
    d[DW-1:0] = 8'd3;
    drive('1, d);
    d = $urandom;
    d[DW-1:0] = 8'd4;
    drive('1, d);
    finish_pass("overwrite");
    checks++;
    if (mem[0][5] !== 8'd3 || mem[0][6] !== 8'd4) begin
      errors++;
      $display("FAIL overwrite rows: got %0d,%0d, required 3,4", mem[0][5], mem[0][6]);
    end
  endtask
  task automatic test_accumulate();
    logic [DW*C-1:0] d;
    begin_pass(10, 1, 1);
    d = $urandom;
    d[2*DW +: DW] = 8'd20;
    drive('1, d);
    finish_pass("acc_preload");
    begin_pass(10, 1, 0);
    d = $urandom;
    d[2*DW +: DW] = 8'd7;
    drive('1, d);
    finish_pass("accumulate");
    checks++;
    if (mem[2][10] !== 8'd27) begin
      errors++;
      $display("FAIL accumulate row10 col2: got %0d, required 27", mem[2][10]);
    end
  endtask
  task automatic test_skew();
    logic [C-1:0] v;
    begin_pass($urandom_range(0, N - 1), 3, 0);
    for (int t = 0; t < C + 2; t++) begin
      for (int c = 0; c < C; c++) v[c] = t >= c && t < c + 3;
      drive(v, $urandom);
    end
    finish_pass("skew");
  endtask
  task automatic test_wrap();
    logic [DW*C-1:0] d;
    logic [DW-1:0] want;
`ifdef ACCUM_RMW_SAT_EN
    want = 8'd127;
`else
    want = 8'h82;
`endif
    begin_pass(15, 2, 1);
    d = $urandom;
    d[DW +: DW] = 8'd120;
    drive('1, d);
    drive('1, $urandom);
    finish_pass("wrap_preload");
    begin_pass(15, 2, 0);
    d = $urandom;
    d[DW +: DW] = 8'd10;
    drive('1, d);
    drive('1, $urandom);
    finish_pass("wrap");
    checks++;
    if (mem[1][15] !== want) begin
      errors++;
      $display("FAIL overflow row15 col1: got %0d, required %0d", mem[1][15], want);
    end
  endtask
  task automatic test_errors();
    drive(4'b0100, $urandom);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got err=%0b busy=%0b, required err=1 busy=0", err, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %0b, required 1", err);
    end
    begin_pass($urandom_range(0, N - 1), 1, 0);
    drive(4'b0001, $urandom);
    drive(4'b0001, $urandom);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL extra_valid: got err=%0b busy=%0b, required err=1 busy=1", err, busy);
    end
    drive(4'b1110, $urandom);
    finish_pass("extra_valid");
    begin_pass($urandom_range(0, N - 1), 1, 0);
    drive('1, $urandom);
    finish_pass("err_clear");
  endtask
  task automatic test_reset_mid();
    snap = mdl;
    wsnap = wrt;
    begin_pass($urandom_range(0, N - 1), 4, 0);
    drive('1, $urandom);
    reset = 1;
    @(negedge clk);
    for (int c = 0; c < C; c++) begin
      rq[c].delete();
      wq[c].delete();
    end
    mdl = snap;
    wrt = wsnap;
    run = 0;
    exp_err = 0;
    checks++;
    if ({busy, done, err} !== 3'b000 || tbl_wr_en !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy/done/err=%b wr_en=%b, required 000 and 0", {busy, done, err}, tbl_wr_en);
    end
    reset = 0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < C; c++) begin
      bit bad = 0;
      for (int a = 0; a < N; a++) if (wrt[c][a] && mem[c][a] !== mdl[c][a]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL reset_mid table col%0d: contents changed, required unchanged", c);
      end
    end
    begin_pass($urandom_range(0, N - 1), 3, 0);
    for (int t = 0; t < 3; t++) drive('1, $urandom);
    finish_pass("after_reset");
  endtask
  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      begin_pass($urandom_range(0, N - 1), $urandom_range(1, N), 1'($urandom_range(0, 1)));
      for (int t = 0; t < 200 && !pass_full(); t++) drive(C'($urandom), $urandom);
      finish_pass("random");
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_overwrite();
    test_accumulate();
    test_skew();
    test_wrap();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accum_rmw_ctrl.md
Name: accum_rmw_ctrl

Overview:
- Read-modify-write initiator that drives the per-column accumulator table from the systolic array output side.
- Takes skewed per-column partial sums and generates per-column row addresses from a base plus a row counter.
- Issues table reads, adds each partial sum to the stored value, and writes the result back.
- Sits between the systolic array bottom edge and the accumulator table. It is the only driver of the table's rd/wr ports during a compute pass.

Parameters:
- DATA_WIDTH, 8, bits per accumulator entry and per partial sum.
- MAX_OUT_ROWS, 128, maximum output rows.
- MAX_OUT_COLS, 128, maximum output columns.
- SYS_ARR_COLS, 16, number of columns (lanes).
- Derived: NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS); ADDR_W = $clog2(NUM_ACCUM_ROWS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; accepted only in IDLE
- base_addr  in  ADDR_W  first table row of the pass; latched on start
- num_rows  in  ADDR_W+1  rows per column in the pass (1..NUM_ACCUM_ROWS); latched on start
- overwrite  in  1  1 = write psum directly with no read (first K-tile); latched on start
- psum_valid  in  SYS_ARR_COLS  per-column partial-sum strobe
- psum_data  in  DATA_WIDTH*SYS_ARR_COLS  partial sums, column c at [c*DATA_WIDTH +: DATA_WIDTH]
- tbl_rd_en  out  SYS_ARR_COLS  table read enables
- tbl_rd_addr  out  ADDR_W*SYS_ARR_COLS  table read addresses
- tbl_rd_data  in  DATA_WIDTH*SYS_ARR_COLS  table read data, one-cycle latency
- tbl_wr_en  out  SYS_ARR_COLS  table write enables
- tbl_wr_addr  out  ADDR_W*SYS_ARR_COLS  table write addresses
- tbl_wr_data  out  DATA_WIDTH*SYS_ARR_COLS  table write data
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  sticky protocol error; cleared by an accepted start or by reset

Behaviour:
- Clock and reset are fixed: single clock clk; reset is synchronous and active-high.
- On reset:
  - All outputs are 0 and the state is IDLE.
  - Row counters and pipeline valids are cleared.
  - Any in-flight pipeline contents are discarded; no table write issues after a reset cycle.
- IDLE:
  - start=1 latches base_addr, num_rows and overwrite, clears per-column row counters r[c] and err, and goes to RUN.
  - Any psum_valid bit seen in IDLE sets err and is ignored.
- RUN, per column c, independent of other columns:
  - psum_valid[c] in cycle T with r[c]<num_rows accepts the sample at address A = (base_addr + r[c]) mod 2^ADDR_W, then r[c] increments.
  - T+1 (registered): tbl_rd_en[c]=1 and tbl_rd_addr[c]=A; psum is held in the pipeline register. In overwrite mode tbl_rd_en[c] stays 0.
  - T+2: tbl_rd_data[c] is valid; the sum is formed as stored + psum, or psum alone in overwrite mode.
  - T+3 (registered): tbl_wr_en[c]=1, tbl_wr_addr[c]=A, tbl_wr_data[c]=result.
  - Total latency from psum_valid to write is 3 cycles. Each column accepts one sample per cycle, fully pipelined.
  - Addresses within a pass are distinct, so there is no RAW forwarding.
  - psum_valid[c] when r[c]==num_rows sets err; the sample is dropped and no table access is made.
  - When every r[c]==num_rows (including in the same cycle as the last accept), go to DRAIN.
- DRAIN:
  - Wait until all pipeline valids are 0 (at most 3 cycles after the last accept).
  - Then pulse done for 1 cycle and return to IDLE.
  - busy falls in the same cycle done is asserted.
- start while busy is ignored.
- psum_valid arriving in DRAIN sets err and is dropped.
- Arithmetic: two's-complement DATA_WIDTH add with wrap-around; the carry is discarded.
- Enables are 0 whenever their stage is invalid. Address and data outputs are don't-care when their enable is 0 and are held at their previous values.

Optional Feature:
- Macro ACCUM_RMW_SAT_EN.
- Defined: the adder is signed saturating. Results clamp to +(2^(DATA_WIDTH-1)-1) or -(2^(DATA_WIDTH-1)). Overwrite mode is unaffected.
- Undefined: wrap-around add as above.
- Latency is identical in both builds.

Test Plan:
- Overwrite pass: start, base_addr=5, num_rows=2, overwrite=1; col0 valid with data 3 then 4 on consecutive cycles -> no rd_en; wr_en[0] at T+3 and T+4 with addresses 5,6 and data 3,4; done pulses after the pipeline empties.
- Accumulate: table row 10 col2 holds 20; overwrite=0, base=10, num_rows=1, psum 7 on col2 -> rd_en[2] at T+1 with addr 10; wr at T+3 with addr 10 and data 27.
- Skew: 4-column configuration, each column's valid delayed by c cycles, num_rows=3 -> each column writes addresses base..base+2 in order; done only after col3's last write.
- Wrap: NUM_ACCUM_ROWS=16, base=15, num_rows=2 -> write addresses 15 then 0. Overflow: 8-bit, stored 120 + psum 10 -> 130 wraps to -126, or 127 with ACCUM_RMW_SAT_EN.
- Errors: psum_valid in IDLE -> err=1 and no table access. An extra valid after num_rows in RUN -> err=1 with the sample dropped. A new start -> err=0.
- Reset mid-pass: assert reset 1 cycle after an accept -> no wr_en follows; busy=0, done=0; a new pass then runs correctly.
